// File: rtl/vlan_path_arbiter.sv
// vlan_path_arbiter
//   Packet-granular round-robin arbiter sharing the VLAN tagging datapath
//   between NUM_QUEUES sources. Each source feeds a small fall-through FIFO.
//   Whole packets are forwarded unmodified and never interleaved. There is one
//   idle bubble between packets.
//
//   Optional feature macro: VLAN_ARB_STRICT_PRIO_EN
//     defined   -> queue 0 has strict priority. Queues 1..N-1 are round-robin
//                  among themselves. Queue-0 packets do not move last_grant.
//     undefined -> plain round-robin over all queues.
//
// Ports
//   clk, reset  clock; synchronous active-high reset (also flushes the FIFOs)
//   in_data     NUM_QUEUES*DATA_WIDTH; queue i is at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_ctrl     NUM_QUEUES*CTRL_WIDTH; queue i is at [i*CTRL_WIDTH +: CTRL_WIDTH]
//   in_wr       per-queue write strobe
//   in_rdy      per-queue ready (input FIFO not nearly full)
//   out_data    registered output data
//   out_ctrl    registered output ctrl
//   out_wr      registered output write strobe
//   out_rdy     downstream ready
//   cur_queue   queue currently granted
//   busy        high while a packet is in progress
module vlan_path_arbiter #(
  parameter int DATA_WIDTH      = 64,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int NUM_QUEUES      = 4,
  parameter int QUEUE_SEL_WIDTH = 2,
  parameter int FIFO_DEPTH_BITS = 3
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  output logic [NUM_QUEUES-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [CTRL_WIDTH-1:0]            out_ctrl,
  output logic                             out_wr,
  input  logic                             out_rdy,
  output logic [QUEUE_SEL_WIDTH-1:0]       cur_queue,
  output logic                             busy
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_BITS;
  localparam int unsigned NQ    = NUM_QUEUES;
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE  = 1;
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_FULL = DEPTH[FIFO_DEPTH_BITS:0];
  localparam logic [FIFO_DEPTH_BITS:0]   CNT_NF   = CNT_FULL - CNT_ONE;
  localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE  = 1;

  typedef enum logic [1:0] {IDLE, IN_HDR, IN_PAYLOAD} state_t;

  state_t state, state_next;
  logic [QUEUE_SEL_WIDTH-1:0] last_grant, last_grant_next, cur_queue_next, grant_q;
  logic                       found;
  int unsigned                idx;

  logic [NUM_QUEUES-1:0]                 empty, rd_en;
  logic [NUM_QUEUES-1:0][DATA_WIDTH-1:0] head_data;
  logic [NUM_QUEUES-1:0][CTRL_WIDTH-1:0] head_ctrl;
  logic [DATA_WIDTH-1:0]                 sel_data;
  logic [CTRL_WIDTH-1:0]                 sel_ctrl;
  logic                                  rd;

  // Per-queue fall-through FIFOs. The head word is visible while the FIFO is not empty.
  for (genvar g = 0; g < NUM_QUEUES; g++) begin : g_fifo
    logic [DATA_WIDTH-1:0]      mem_d [DEPTH];
    logic [CTRL_WIDTH-1:0]      mem_c [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]   count;
    logic                       wr_en;

    assign wr_en        = in_wr[g] && (count != CNT_FULL);
    assign empty[g]     = (count == '0);
    assign in_rdy[g]    = (count < CNT_NF);
    assign head_data[g] = mem_d[rd_ptr];
    assign head_ctrl[g] = mem_c[rd_ptr];

    always_ff @(posedge clk) begin
      if (wr_en) begin
        mem_d[wr_ptr] <= in_data[g*DATA_WIDTH +: DATA_WIDTH];
        mem_c[wr_ptr] <= in_ctrl[g*CTRL_WIDTH +: CTRL_WIDTH];
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en)    wr_ptr <= wr_ptr + PTR_ONE;
        if (rd_en[g]) rd_ptr <= rd_ptr + PTR_ONE;
        case ({wr_en, rd_en[g]})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end
    end
  end

  assign sel_data = head_data[cur_queue];
  assign sel_ctrl = head_ctrl[cur_queue];
  assign rd       = (state != IDLE) && out_rdy && !empty[cur_queue];
  assign busy     = (state != IDLE);

  always_comb begin
    rd_en            = '0;
    rd_en[cur_queue] = rd;
  end

  // Grant selection. The scan starts one past last_grant and wraps.
  always_comb begin
    found   = 1'b0;
    grant_q = cur_queue;
    idx     = 0;
`ifdef VLAN_ARB_STRICT_PRIO_EN
    if (!empty[0]) begin
      found   = 1'b1;
      grant_q = '0;
    end
`endif
    for (int unsigned i = 1; i <= NQ; i++) begin
      idx = (32'(last_grant) + i) % NQ;
`ifdef VLAN_ARB_STRICT_PRIO_EN
      if (!found && idx != 0 && !empty[QUEUE_SEL_WIDTH'(idx)]) begin
`else
      if (!found && !empty[QUEUE_SEL_WIDTH'(idx)]) begin
`endif
        found   = 1'b1;
        grant_q = QUEUE_SEL_WIDTH'(idx);
      end
    end
  end

  always_comb begin
    state_next      = state;
    cur_queue_next  = cur_queue;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (found) begin
          cur_queue_next = grant_q;
          state_next     = IN_HDR;
        end
      end
      IN_HDR: begin
        if (rd && sel_ctrl == '0) state_next = IN_PAYLOAD;
      end
      IN_PAYLOAD: begin
        if (rd && sel_ctrl != '0) begin
          state_next = IDLE;
`ifdef VLAN_ARB_STRICT_PRIO_EN
          if (cur_queue != '0) last_grant_next = cur_queue;
`else
          last_grant_next = cur_queue;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_queue  <= '0;
      last_grant <= QUEUE_SEL_WIDTH'(NUM_QUEUES - 1);
      out_wr     <= 1'b0;
      out_data   <= '0;
      out_ctrl   <= '0;
    end else begin
      state      <= state_next;
      cur_queue  <= cur_queue_next;
      last_grant <= last_grant_next;
      out_wr     <= rd;
      if (rd) begin
        out_data <= sel_data;
        out_ctrl <= sel_ctrl;
      end
    end
  end

endmodule
